alu_result_bcd: RTL and testbench
=================================

# alu_result_bcd

Sequential converter sitting directly downstream of the ALU's two's-complement stage: it accepts one 6-bit signed result, takes its magnitude, and runs a shift-and-add-3 (double-dabble) conversion to produce a sign flag plus two BCD digits for the 7-segment display driver. Transfers use a valid/ready handshake on both sides; one conversion is in flight at a time.

## Interface
- N_BITS, 6, operand width in bits; only 6 is supported, giving a magnitude of 0..32 and two BCD digits.
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dato  in  6  two's-complement operand, range -32..+31.
- in_valid  in  1  dato is valid.
- in_ready  out  1  block can accept an operand.
- signo  out  1  1 = operand was negative.
- decenas  out  4  BCD tens digit, 0..3.
- unidades  out  4  BCD units digit, 0..9.
- out_valid  out  1  signo/decenas/unidades are valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture signo=dato[5] and mag = dato[5] ? (~dato+1) : dato, computed 7 bits wide and stored in a 6-bit shift register.
  - -32 yields mag=32 (6'b100000); there is no overflow case.
  - Clear the 8-bit BCD accumulator and bit counter; go to CONV.
- CONV:
  - in_ready=0; in_valid is ignored.
  - Each cycle: apply add-3 to each BCD digit that is ≥5, then shift {bcd, mag} left by one.
  - Counter runs 0..5; after the 6th shift go to DONE.
- DONE:
  - out_valid=1; outputs are stable and do not change while out_valid=1 && out_ready=0.
  - On out_valid&&out_ready, go to IDLE and drop out_valid.
  - decenas/unidades/signo keep their last values until the next conversion's DONE.
- Zero operand: signo=0, decenas=0, unidades=0. There is no negative zero.
- No accept in the same cycle as a handoff: in_ready rises only in the cycle after DONE→IDLE.

## Timing
- Reset (asynchronous, immediate on rst_n low, in any state including mid-CONV):
  - State=IDLE.
  - in_ready=1 after reset; out_valid=0, signo=0, decenas=0, unidades=0.
  - The partial conversion is discarded.
- Latency:
  - Accept at edge E0.
  - Shifts at edges E1..E6.
  - out_valid is high after E6, i.e. 6 cycles from the accept edge.
- Throughput: one result per 8 cycles when out_ready is held high (accept, 6 shifts, 1 handoff cycle in DONE).
- out_valid never depends combinationally on out_ready; in_ready never depends combinationally on in_valid.
- Back-pressure: DONE is held indefinitely; no result is lost or overwritten.

## Structure
- Shared package:
  - N_BITS=6.
  - BCD digit width 4.
  - Add-3 threshold 5 and correction constant 3.
  - State enum {IDLE, CONV, DONE}.
  - Counter width 3.
- Sub-module bcd_add3_cell: combinational 4-bit digit correction (in ≥5 → in+3, else in). Instantiate it twice, once per digit.
- Top level holds the FSM, shift register, counter and output registers.

## Test plan
- Reset, then dato=6'b000000 accepted → after 6 cycles out_valid=1, signo=0, decenas=0, unidades=0.
- dato=6'b011111 (+31) → signo=0, decenas=3, unidades=1. Then dato=6'b100000 (-32) → signo=1, decenas=3, unidades=2.
- dato=6'b110101 (-11) with out_ready held low for 20 cycles:
  - Outputs stay signo=1, decenas=1, unidades=1 and out_valid=1 throughout; in_ready=0.
  - Raising out_ready → out_valid falls next edge, then in_ready=1.
- in_valid pulsed with a new value while in CONV → ignored; the result matches the first operand only.
- rst_n asserted at the 3rd CONV cycle → immediately in_ready=1, out_valid=0, all outputs 0. A following dato=6'b000111 converts normally to 0/0/7.
- Exhaustive sweep of all 64 values with random out_ready stalls → every result matches the sign and decimal magnitude of the operand; 8-cycle spacing when unstalled.

Source files
------------

// File: rtl/alu_result_bcd_pkg.sv
// Shared constants and types for the signed-result to two-digit BCD converter.
package alu_result_bcd_pkg;

  localparam int N_BITS = 6;
  localparam int BCD_W  = 4;
  localparam int CNT_W  = 3;

  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] ADD3_CORR   = 4'd3;
  localparam logic [CNT_W-1:0] LAST_SHIFT  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_result_bcd_add3_cell.sv
// Double-dabble digit correction: digits of 5 or more get 3 added before the shift.
module bcd_add3_cell
  import alu_result_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  output logic [BCD_W-1:0] digit_out
);

  always_comb begin
    if (digit_in >= ADD3_THRESH) begin
      digit_out = digit_in + ADD3_CORR;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/alu_result_bcd.sv
// Converts one 6-bit two's-complement ALU result into a sign flag plus tens/units
// BCD digits using a six-step shift-and-add-3 sequence behind valid/ready handshakes.
module alu_result_bcd
  import alu_result_bcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] dato,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              signo,
  output logic [BCD_W-1:0]  decenas,
  output logic [BCD_W-1:0]  unidades,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t             state_q, state_d;
  logic [N_BITS-1:0]  mag_q, mag_d;
  logic [7:0]         bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               signo_q, signo_d;
  logic [BCD_W-1:0]   decenas_q, decenas_d;
  logic [BCD_W-1:0]   unidades_q, unidades_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [N_BITS:0]    mag7_s;
  logic [BCD_W-1:0]   tens_adj_s, units_adj_s;
  logic [7:0]         bcd_shift_s;

  // One extra bit so that -32 negates cleanly to +32.
  assign mag7_s = dato[N_BITS-1] ? (~{dato[N_BITS-1], dato} + 7'd1) : {1'b0, dato};

  bcd_add3_cell u_tens  (.digit_in(bcd_q[7:4]), .digit_out(tens_adj_s));
  bcd_add3_cell u_units (.digit_in(bcd_q[3:0]), .digit_out(units_adj_s));

  assign bcd_shift_s = {tens_adj_s[2:0], units_adj_s, mag_q[N_BITS-1]};

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    signo_d     = signo_q;
    decenas_d   = decenas_q;
    unidades_d  = unidades_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d     = dato[N_BITS-1];
          mag_d      = mag7_s[N_BITS-1:0];
          bcd_d      = 8'd0;
          cnt_d      = 3'd0;
          in_ready_d = 1'b0;
          state_d    = CONV;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      CONV: begin
        mag_d = {mag_q[N_BITS-2:0], 1'b0};
        bcd_d = bcd_shift_s;
        cnt_d = cnt_q + 3'd1;
        // Results are published from the final shift so out_valid rises with the data.
        if (cnt_q == LAST_SHIFT) begin
          signo_d     = sign_q;
          decenas_d   = bcd_shift_s[7:4];
          unidades_d  = bcd_shift_s[3:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = CONV;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= 6'd0;
      bcd_q       <= 8'd0;
      cnt_q       <= 3'd0;
      sign_q      <= 1'b0;
      signo_q     <= 1'b0;
      decenas_q   <= 4'd0;
      unidades_q  <= 4'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      signo_q     <= signo_d;
      decenas_q   <= decenas_d;
      unidades_q  <= unidades_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign signo     = signo_q;
  assign decenas   = decenas_q;
  assign unidades  = unidades_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Directed and sweep bench for alu_result_bcd with a queue-based scoreboard.
module tb_alu_result_bcd;

  logic       clk;
  logic       rst_n;
  logic [5:0] dato;
  logic       in_valid;
  logic       in_ready;
  logic       signo;
  logic [3:0] decenas;
  logic [3:0] unidades;
  logic       out_valid;
  logic       out_ready;

  typedef struct packed {
    logic       s;
    logic [3:0] d;
    logic [3:0] u;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  time  last_accept_t = 0;

  alu_result_bcd dut (
    .clk(clk), .rst_n(rst_n), .dato(dato), .in_valid(in_valid), .in_ready(in_ready),
    .signo(signo), .decenas(decenas), .unidades(unidades),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [5:0] v);
    int   mag;
    exp_t e;
    mag = v[5] ? (64 - int'(v)) : int'(v);
    e.s = v[5];
    e.d = 4'(mag / 10);
    e.u = 4'(mag % 10);
    return e;
  endfunction

  // Called right after a falling edge. Pushes the expectation, drives the operand,
  // optionally injects a spurious operand during CONV, stalls the result, then hands off.
  task automatic convert(input logic [5:0] v, input int stall, input bit check_gap,
                         input bit inject, input logic [5:0] inj_v);
    int   n;
    exp_t e;
    exp_q.push_back(model(v));
    dato = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 8'd0, 8'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (check_gap) chk("gap_cycles", 8'(($time - last_accept_t) / 10), 8'd8);
    last_accept_t = $time;
    @(negedge clk);
    in_valid = 1'b0;
    dato = 6'd0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (inject && n == 2) begin
        chk("in_ready_conv", 8'(in_ready), 8'd0);
        dato = inj_v;
        in_valid = 1'b1;
      end else if (inject && n == 3) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("latency", 8'(n), 8'd6);
    if (exp_q.size() == 0) begin
      chk("queue_empty", 8'd0, 8'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 8'(out_valid), 8'd1);
      chk("stall_ready", 8'(in_ready), 8'd0);
      chk("stall_data", {signo, decenas, unidades[2:0]}, {e.s, e.d, e.u[2:0]});
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("signo", 8'(signo), 8'(e.s));
    chk("decenas", 8'(decenas), 8'(e.d));
    chk("unidades", 8'(unidades), 8'(e.u));
    chk("handoff_in_ready", 8'(in_ready), 8'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 8'(out_valid), 8'd0);
    chk("post_in_ready", 8'(in_ready), 8'd1);
    chk("hold_unidades", 8'(unidades), 8'(e.u));
  endtask

  initial begin
    int st;
    int prev_st;
    rst_n = 1'b0;
    dato = 6'd0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_data", {3'd0, signo, decenas}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(6'b000000, 0, 1'b0, 1'b0, 6'd0);
    convert(6'b011111, 0, 1'b1, 1'b0, 6'd0);
    convert(6'b100000, 0, 1'b1, 1'b0, 6'd0);
    convert(6'b110101, 20, 1'b1, 1'b0, 6'd0);
    convert(6'b000101, 0, 1'b0, 1'b1, 6'b111111);

    // Abort a conversion with reset during its third CONV cycle.
    dato = 6'b101010;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 8'(in_ready), 8'd1);
    chk("abort_out_valid", 8'(out_valid), 8'd0);
    chk("abort_data", {signo, decenas, unidades[2:0]}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    convert(6'b000111, 0, 1'b0, 1'b0, 6'd0);

    prev_st = 1;
    for (int i = 0; i < 64; i++) begin
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      convert(6'(i), st, (i > 0) && (prev_st == 0), 1'b0, 6'd0);
      prev_st = st;
    end

    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
